// File: rtl/rv_deserializer.sv
// rv_deserializer: packs RATIO ready/valid input beats (or fewer on last_in) into one wide output word
module rv_deserializer #(
    parameter int DATAW = 8,
    parameter int RATIO = 4,
    parameter int CNTW  = $clog2(RATIO)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [DATAW-1:0]       data_in,
    input  logic                   last_in,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [DATAW*RATIO-1:0] data_out,
    output logic [CNTW:0]          count_out
);
    logic [CNTW-1:0]        cnt;
    logic [DATAW*RATIO-1:0] acc;
    logic [DATAW*RATIO-1:0] merged;
    logic                   take;
    logic                   done;

    assign ready_in = !valid_out || ready_out;
    assign take     = valid_in && ready_in;
    assign done     = take && (last_in || cnt == CNTW'(RATIO - 1));

    for (genvar i = 0; i < RATIO; i++) begin : g_slot
        assign merged[i*DATAW +: DATAW] = (cnt == CNTW'(i)) ? data_in : acc[i*DATAW +: DATAW];
    end

    // accumulate beats, publish the word on the completing beat, hold it until handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            count_out <= '0;
        end else if (done) begin
            cnt       <= '0;
            acc       <= '0;
            valid_out <= 1'b1;
            data_out  <= merged;
            count_out <= {1'b0, cnt} + {{CNTW{1'b0}}, 1'b1};
        end else begin
            if (take) begin
                cnt <= cnt + CNTW'(1);
                acc <= merged;
            end
            if (valid_out && ready_out) valid_out <= 1'b0;
        end
    end
endmodule

// File: doc/rv_deserializer.md
RV_DESERIALIZER -- requirements
Module: RV_deserializer

Interface
REQ-001 SHALL have parameter DATAW, default 8, meaning input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning beats packed per output word (RATIO >= 2).
REQ-003 SHALL have parameter CNTW, default $clog2(RATIO), meaning beat-counter width.
REQ-004 SHALL have port clk  input  1  clock; one clock only, all state rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_in  input  1  input beat valid.
REQ-007 SHALL have port ready_in  output  1  block accepts input beat.
REQ-008 SHALL have port data_in  input  DATAW  input beat.
REQ-009 SHALL have port last_in  input  1  beat closes current word early.
REQ-010 SHALL have port valid_out  output  1  packed word valid.
REQ-011 SHALL have port ready_out  input  1  downstream accepts word.
REQ-012 SHALL have port data_out  output  DATAW*RATIO  packed word.
REQ-013 SHALL have port count_out  output  CNTW+1  beats held in data_out, 1..RATIO.

Function
REQ-014 Input handshake SHALL be valid_in && ready_in; output handshake valid_out && ready_out.
REQ-015 ready_in SHALL equal !valid_out || ready_out (only combinational path: ready_out -> ready_in).
REQ-016 Accepted beat k (k = beat counter value, 0 first) SHALL be written to accumulator bits [k*DATAW +: DATAW]; beat 0 at LSB.
REQ-017 Beat counter SHALL increment by 1 per accepted non-completing beat.
REQ-018 Completing beat = accepted beat with counter == RATIO-1 or last_in == 1.
REQ-019 On completing beat, next cycle: data_out = accumulator with this beat merged, unwritten slots zero; count_out = counter+1; valid_out = 1; counter and accumulator cleared to 0.
REQ-020 Latency: completing beat accepted in cycle N -> valid_out high in cycle N+1.
REQ-021 valid_out, data_out, count_out SHALL be stable while valid_out && !ready_out.
REQ-022 valid_out SHALL clear after output handshake unless a completing beat is accepted in the same cycle, in which case the new word replaces it with valid_out staying 1 (back-to-back, no bubble).
REQ-023 Non-completing beats SHALL only be accepted under REQ-015; no beat accumulates while output is blocked.
REQ-024 With ready_out held 1 and valid_in held 1, throughput SHALL be one beat per cycle, one word per RATIO cycles.
REQ-025 last_in on beat 0 SHALL yield count_out = 1, upper RATIO-1 slots zero.
REQ-026 last_in on beat RATIO-1 SHALL behave identically to last_in = 0 on that beat.
REQ-027 data_in and last_in SHALL be ignored when valid_in && ready_in is false.
REQ-028 Counter SHALL never exceed RATIO-1; wrap to 0 only via completion.

Reset
REQ-029 Reset in any cycle SHALL take priority over all handshakes.
REQ-030 After reset: valid_out = 0, data_out = 0, count_out = 0, counter = 0, accumulator = 0, ready_in = 1.
REQ-031 Reset mid-word SHALL discard partial beats; reset while valid_out = 1 SHALL drop the pending word without handshake.

Verification (DATAW=8, RATIO=4)
REQ-032 Beats 0x11,0x22,0x33,0x44, ready_out=1 -> cycle after 4th beat: valid_out=1, data_out=0x44332211, count_out=4.
REQ-033 Beats 0xAA,0xBB with last_in on 0xBB -> data_out=0x0000BBAA, count_out=2; next word starts at slot 0.
REQ-034 Word pending, ready_out=0 for 5 cycles, valid_in=1 -> ready_in=0, outputs stable, no beats consumed; ready_out=1 -> handshake, ready_in=1 same cycle.
REQ-035 Continuous valid_in and ready_out, 8 beats 0x01..0x08 -> words 0x04030201 then 0x08070605, valid_out high exactly on 2 cycles at 4-cycle spacing.
REQ-036 Reset after 2 beats, then 0x55,0x66,0x77,0x88 -> data_out=0x88776655, count_out=4; no stale data.
REQ-037 Single beat 0x9C with last_in while ready_out=1 and prior word draining -> prior word handshakes, next cycle data_out=0x0000009C, count_out=1, valid_out continuously 1.
